// File: rtl/axi4lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_pkg
// Description : Shared AXI4-Lite response codes and read-arbiter FSM encoding.
//               The ERR state exists only with AXI4LITE_RD_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4lite_pkg;

    localparam logic [1:0] C_RESP_OKAY   = 2'b00;
    localparam logic [1:0] C_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
`ifdef AXI4LITE_RD_ARB_TIMEOUT_EN
        ST_DATA = 2'd2,
        ST_ERR  = 2'd3
`else
        ST_DATA = 2'd2
`endif
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/axi4lite_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_rr_arbiter2
// Description : Two-requester grant selection with a round-robin priority
//               pointer that flips away from the master just served.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_upd_en,
    input  logic       i_upd_id,
    output logic       o_gnt_valid,
    output logic       o_gnt_id
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        o_gnt_valid = |i_req;
        case (i_req)
            2'b10:   o_gnt_id = 1'b1;
            2'b11:   o_gnt_id = prio_q;
            default: o_gnt_id = 1'b0;
        endcase
        prio_d = i_upd_en ? ~i_upd_id : prio_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi4lite_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_read_arbiter
// Description : Arbitrates two AXI4-Lite read masters onto one slave, one
//               transaction outstanding. Optional abort: AXI4LITE_RD_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_read_arbiter
    import axi4lite_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        s0_arvalid,
    output logic        s0_arready,
    input  logic [31:0] s0_araddr,
    input  logic [2:0]  s0_arprot,
    output logic        s0_rvalid,
    input  logic        s0_rready,
    output logic [31:0] s0_rdata,
    output logic [1:0]  s0_rresp,
    input  logic        s1_arvalid,
    output logic        s1_arready,
    input  logic [31:0] s1_araddr,
    input  logic [2:0]  s1_arprot,
    output logic        s1_rvalid,
    input  logic        s1_rready,
    output logic [31:0] s1_rdata,
    output logic [1:0]  s1_rresp,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [31:0] m_araddr,
    output logic [2:0]  m_arprot,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp
);

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("TIMEOUT must be at least 1");
    end

    arb_state_e  state_q, state_d;
    logic        gnt_q, gnt_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  prot_q, prot_d;

    logic        w_gnt_valid;
    logic        w_gnt_id;
    logic        w_ar_accept;
    logic        w_done;
    logic        w_sel_rready;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic [1:0]  w_rresp;

`ifdef AXI4LITE_RD_ARB_TIMEOUT_EN
    localparam int             C_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT - 1);
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
`endif

    axi4lite_rr_arbiter2 u_rr_arbiter (
        .clk         (aclk),
        .rst_n       (aresetn),
        .i_req       ({s1_arvalid, s0_arvalid}),
        .i_upd_en    (w_done),
        .i_upd_id    (gnt_q),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id)
    );

    assign w_sel_rready = gnt_q ? s1_rready : s0_rready;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        addr_d      = addr_q;
        prot_d      = prot_q;
        w_ar_accept = 1'b0;
        w_done      = 1'b0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        w_rvalid    = 1'b0;
        w_rdata     = '0;
        w_rresp     = C_RESP_OKAY;
`ifdef AXI4LITE_RD_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Gated by aresetn so arready stays low while reset is held.
                if (w_gnt_valid && aresetn) begin
                    w_ar_accept = 1'b1;
                    gnt_d       = w_gnt_id;
                    addr_d      = w_gnt_id ? s1_araddr : s0_araddr;
                    prot_d      = w_gnt_id ? s1_arprot : s0_arprot;
                    state_d     = ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                w_rvalid = m_rvalid;
                w_rdata  = m_rdata;
                w_rresp  = m_rresp;
                m_rready = w_sel_rready;
                if (m_rvalid && w_sel_rready) begin
                    w_done  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
`ifdef AXI4LITE_RD_ARB_TIMEOUT_EN
            ST_ERR: begin
                // Sink any late slave beat while reporting SLVERR upstream.
                m_rready = 1'b1;
                w_rvalid = 1'b1;
                w_rresp  = C_RESP_SLVERR;
                if (w_sel_rready) begin
                    w_done  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
`ifdef AXI4LITE_RD_ARB_TIMEOUT_EN
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if ((state_q == ST_ADDR || state_q == ST_DATA) && !w_done) begin
            if (cnt_q == C_CNT_LAST) begin
                state_d = ST_ERR;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            addr_q  <= '0;
            prot_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            prot_q  <= prot_d;
        end
    end

`ifdef AXI4LITE_RD_ARB_TIMEOUT_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign m_araddr   = addr_q;
    assign m_arprot   = prot_q;

    assign s0_arready = w_ar_accept & ~w_gnt_id;
    assign s1_arready = w_ar_accept &  w_gnt_id;

    assign s0_rvalid  = w_rvalid & ~gnt_q;
    assign s1_rvalid  = w_rvalid &  gnt_q;
    assign s0_rdata   = gnt_q ? '0 : w_rdata;
    assign s1_rdata   = gnt_q ? w_rdata : '0;
    assign s0_rresp   = gnt_q ? C_RESP_OKAY : w_rresp;
    assign s1_rresp   = gnt_q ? w_rresp : C_RESP_OKAY;

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4lite_read_arbiter
// Description : Self-checking bench: directed scenarios then randomized
//               transactions against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4lite_read_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
    logic [31:0] s0_araddr, s0_rdata;
    logic [2:0]  s0_arprot;
    logic [1:0]  s0_rresp;
    logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
    logic [31:0] s1_araddr, s1_rdata;
    logic [2:0]  s1_arprot;
    logic [1:0]  s1_rresp;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_araddr, m_rdata;
    logic [2:0]  m_arprot;
    logic [1:0]  m_rresp;

    axi4lite_read_arbiter #(.TIMEOUT(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
        .s0_arprot(s0_arprot), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
        .s1_arprot(s1_arprot), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arprot(m_arprot), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rresp(m_rresp)
    );

    always #5 aclk = ~aclk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: who is waiting, with what, and whose turn a tie is.
    int          model_prio;
    logic        pend  [2];
    logic [31:0] paddr [2];
    logic [2:0]  pprot [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic arready_of(input int i);
        return (i == 1) ? s1_arready : s0_arready;
    endfunction
    function automatic logic rvalid_of(input int i);
        return (i == 1) ? s1_rvalid : s0_rvalid;
    endfunction
    function automatic logic [31:0] rdata_of(input int i);
        return (i == 1) ? s1_rdata : s0_rdata;
    endfunction
    function automatic logic [1:0] rresp_of(input int i);
        return (i == 1) ? s1_rresp : s0_rresp;
    endfunction
    function automatic logic rready_of(input int i);
        return (i == 1) ? s1_rready : s0_rready;
    endfunction

    task automatic set_rready(input int i, input logic v);
        if (i == 1) s1_rready = v;
        else        s0_rready = v;
    endtask

    // Idle masters present junk address/prot so only registered values can match.
    task automatic drive_ar();
        s0_arvalid = pend[0];
        s0_araddr  = pend[0] ? paddr[0] : $urandom;
        s0_arprot  = pend[0] ? pprot[0] : 3'($urandom);
        s1_arvalid = pend[1];
        s1_araddr  = pend[1] ? paddr[1] : $urandom;
        s1_arprot  = pend[1] ? pprot[1] : 3'($urandom);
    endtask

    task automatic raise(input int i, input logic [31:0] a, input logic [2:0] p);
        pend[i]  = 1'b1;
        paddr[i] = a;
        pprot[i] = p;
        drive_ar();
    endtask

    // One complete transaction; called just after a rising edge.
    task automatic do_txn(input int ar_dly, input int r_dly, input int stall,
                          input logic [31:0] data, input logic [1:0] resp);
        int g;
        int o;
        if (pend[0] && pend[1]) g = model_prio;
        else                    g = pend[1] ? 1 : 0;
        o = 1 - g;
        drive_ar();
        set_rready(0, 1'b1);
        set_rready(1, 1'b1);
        @(negedge aclk);
        chk("grant_arready", arready_of(g), 1'b1);
        chk("loser_arready", arready_of(o), 1'b0);
        chk("idle_rvalid", {s1_rvalid, s0_rvalid}, 2'b00);
        @(posedge aclk); #1;
        pend[g] = 1'b0;
        drive_ar();
        for (int k = 0; k <= ar_dly; k++) begin
            m_arready = (k == ar_dly);
            @(negedge aclk);
            chk("addr_arvalid", m_arvalid, 1'b1);
            chk("addr_araddr", m_araddr, paddr[g]);
            chk("addr_arprot", m_arprot, pprot[g]);
            chk("addr_other_arready", {s1_arready, s0_arready}, 2'b00);
            chk("addr_rvalid", {s1_rvalid, s0_rvalid}, 2'b00);
            @(posedge aclk); #1;
        end
        m_arready = 1'b0;
        for (int k = 0; k < r_dly + stall + 1; k++) begin
            logic v;
            v         = (k >= r_dly);
            m_rvalid  = v;
            m_rdata   = v ? data : $urandom;
            m_rresp   = v ? resp : 2'($urandom);
            set_rready(g, (k < r_dly) || (k >= r_dly + stall));
            set_rready(o, 1'($urandom));
            @(negedge aclk);
            chk("data_arvalid", m_arvalid, 1'b0);
            chk("data_rready_pass", m_rready, rready_of(g));
            chk("data_rvalid", rvalid_of(g), v);
            if (v) begin
                chk("data_rdata", rdata_of(g), data);
                chk("data_rresp", rresp_of(g), resp);
            end
            chk("other_r", {rvalid_of(o), rdata_of(o), rresp_of(o)}, 35'd0);
            @(posedge aclk); #1;
        end
        m_rvalid   = 1'b0;
        model_prio = (g == 0) ? 1 : 0;
    endtask

    initial begin
        aresetn   = 1'b0;
        pend[0]   = 1'b0;
        pend[1]   = 1'b0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = '0;
        s0_rready = 1'b0;
        s1_rready = 1'b0;
        model_prio = 0;
        drive_ar();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_outputs", {s0_arready, s1_arready, s0_rvalid, s1_rvalid,
                            m_arvalid, m_rready}, 6'd0);
        chk("rst_araddr", {m_araddr, m_arprot}, 35'd0);
        chk("rst_rdata", {s0_rdata, s1_rdata, s0_rresp, s1_rresp}, 68'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Simultaneous pair after reset: s0 first; then s0 re-asks and s1 wins.
        raise(0, 32'h10, 3'd0);
        raise(1, 32'h20, 3'd1);
        do_txn(0, 0, 0, 32'h1111_0000, 2'b00);
        raise(0, 32'h30, 3'd2);
        do_txn(0, 0, 0, 32'h2222_0000, 2'b00);
        do_txn(1, 1, 0, 32'h3333_0000, 2'b00);

        // Single master, fixed data.
        raise(0, 32'h100, 3'd0);
        do_txn(0, 0, 0, 32'hDEAD_BEEF, 2'b00);

        // Slow slave address accept with a competing request outstanding.
        raise(0, 32'hA5A5_0040, 3'd5);
        raise(1, 32'h5A5A_0080, 3'd6);
        do_txn(5, 0, 0, 32'h0BAD_F00D, 2'b01);
        do_txn(0, 2, 0, 32'hCAFE_0001, 2'b11);

        // Upstream back-pressure on read data.
        raise(0, 32'h0000_0C00, 3'd3);
        do_txn(0, 1, 3, 32'h1234_5678, 2'b10);

`ifdef AXI4LITE_RD_ARB_TIMEOUT_EN
        // Unanswered request: SLVERR after TIMEOUT cycles in ADDR.
        raise(0, 32'h200, 3'd1);
        @(negedge aclk);
        chk("to_grant", s0_arready, 1'b1);
        @(posedge aclk); #1;
        pend[0]   = 1'b0;
        drive_ar();
        s0_rready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge aclk);
            chk("to_wait", {m_arvalid, s0_rvalid}, 2'b10);
            @(posedge aclk); #1;
        end
        @(negedge aclk);
        chk("to_err_rvalid", s0_rvalid, 1'b1);
        chk("to_err_rdata", s0_rdata, 32'd0);
        chk("to_err_rresp", s0_rresp, 2'b10);
        chk("to_err_m", {m_arvalid, m_rready, s1_rvalid}, 3'b010);
        @(posedge aclk); #1;
        s0_rready = 1'b1;
        @(negedge aclk);
        chk("to_err_hold", s0_rvalid, 1'b1);
        @(posedge aclk); #1;
        model_prio = 1;
        @(negedge aclk);
        chk("to_back_idle", {s0_rvalid, m_arvalid}, 2'b00);
        @(posedge aclk); #1;
`endif

        // Reset pulse while data is pending; prio must return to s0.
        raise(0, 32'h0000_0044, 3'd0);
        @(posedge aclk); #1;
        pend[0]   = 1'b0;
        drive_ar();
        m_arready = 1'b1;
        @(posedge aclk); #1;
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_rdata   = 32'h7777_7777;
        s0_rready = 1'b0;
        raise(1, 32'h0000_0055, 3'd0);
        @(negedge aclk);
        chk("pre_rst_rvalid", s0_rvalid, 1'b1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("async_rst_valids", {s0_arready, s1_arready, s0_rvalid, s1_rvalid,
                                 m_arvalid, m_rready}, 6'd0);
        chk("async_rst_rdata", {s0_rdata, s0_rresp}, 34'd0);
        @(posedge aclk); #1;
        m_rvalid   = 1'b0;
        pend[1]    = 1'b0;
        drive_ar();
        model_prio = 0;
        aresetn    = 1'b1;
        @(posedge aclk); #1;
        raise(0, 32'h0000_0060, 3'd4);
        raise(1, 32'h0000_0070, 3'd7);
        do_txn(0, 0, 0, 32'hFEED_0001, 2'b00);
        do_txn(0, 0, 0, 32'hFEED_0002, 2'b00);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1))
                    raise(i, $urandom, 3'($urandom));
            end
            if (!pend[0] && !pend[1])
                raise(int'($urandom_range(0, 1)), $urandom, 3'($urandom));
            do_txn(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 3)), $urandom, 2'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
